// File: rtl/decode_queue.sv
// decode_queue: decoded-instruction FIFO between decoder and scheduler, bubble head when empty, flush on taken branch.
// Optional same-cycle bypass through an empty queue under `DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_type,
  input  logic [2:0]       in_unit,
  input  logic [1:0]       in_op,
  input  logic [5:0]       in_r1_rn,
  input  logic [5:0]       in_r2_rn,
  input  logic [5:0]       in_rd_rn,
  input  logic [5:0]       in_rd2_rn,
  input  logic [63:0]      in_imm,
  input  logic [63:0]      in_pc,
  input  logic             sc_ready,
  input  logic             flush,
  output logic             q_valid,
  output logic             q_type,
  output logic [2:0]       q_unit,
  output logic [1:0]       q_op,
  output logic [5:0]       q_r1_rn,
  output logic [5:0]       q_r2_rn,
  output logic [5:0]       q_rd_rn,
  output logic [5:0]       q_rd2_rn,
  output logic [63:0]      q_imm,
  output logic [63:0]      q_pc,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);
  localparam int W = 158;
  logic [W-1:0]     mem [DEPTH];
  logic [W-1:0]     in_word, head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             byp, push, pop;
  assign in_word  = {in_type, in_unit, in_op, in_r1_rn, in_r2_rn, in_rd_rn, in_rd2_rn, in_imm, in_pc};
  assign empty    = count == '0;
  assign full     = count == (PTR_W+1)'(DEPTH);
  assign in_ready = ~full;
`ifdef DECODE_QUEUE_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif
  assign q_valid = ~empty | byp;
  assign pop     = sc_ready & ~empty & ~flush;
  // a bypassed instruction taken by the scheduler this cycle never lands in storage
  assign push    = in_valid & in_ready & ~flush & ~(byp & sc_ready);
  assign head    = byp ? in_word : ~empty ? mem[rd_ptr] : '0;
  assign {q_type, q_unit, q_op, q_r1_rn, q_r2_rn, q_rd_rn, q_rd2_rn, q_imm, q_pc} = head;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_word;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= flush ? '0 : rd_ptr + PTR_W'(pop);
      wr_ptr <= flush ? '0 : wr_ptr + PTR_W'(push);
      count  <= flush ? '0 : count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode_queue fill/drain, streaming, flush, async reset and head latency.
module tb_decode_queue;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_type = 1'b0;
  logic [2:0]  in_unit = '0;
  logic [1:0]  in_op = '0;
  logic [5:0]  in_r1_rn = '0, in_r2_rn = '0, in_rd_rn = '0, in_rd2_rn = '0;
  logic [63:0] in_imm = '0, in_pc = '0;
  logic        sc_ready = 1'b0, flush = 1'b0;
  logic        q_valid, q_type;
  logic [2:0]  q_unit;
  logic [1:0]  q_op;
  logic [5:0]  q_r1_rn, q_r2_rn, q_rd_rn, q_rd2_rn;
  logic [63:0] q_imm, q_pc;
  logic [2:0]  count;
  logic        empty, full;
  int total = 0, bad = 0;

  decode_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_unit(in_unit), .in_op(in_op), .in_r1_rn(in_r1_rn), .in_r2_rn(in_r2_rn),
    .in_rd_rn(in_rd_rn), .in_rd2_rn(in_rd2_rn), .in_imm(in_imm), .in_pc(in_pc),
    .sc_ready(sc_ready), .flush(flush), .q_valid(q_valid), .q_type(q_type), .q_unit(q_unit),
    .q_op(q_op), .q_r1_rn(q_r1_rn), .q_r2_rn(q_r2_rn), .q_rd_rn(q_rd_rn), .q_rd2_rn(q_rd2_rn),
    .q_imm(q_imm), .q_pc(q_pc), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] rd, input logic [63:0] pc);
    in_valid  = v;
    in_rd_rn  = rd;
    in_unit   = rd[2:0];
    in_r1_rn  = rd + 6'd1;
    in_imm    = pc + 64'd1;
    in_pc     = pc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_q_valid", 64'(q_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 6'(k), 64'(k));
      tick();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 6'd5, 64'd5);
    tick();
    chk("over_count", 64'(count), 64'd4);
    chk("over_head", 64'(q_rd_rn), 64'd1);
    drive(1'b0, 6'd0, 64'd0);
    sc_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("drain_head_rd", 64'(q_rd_rn), 64'(k));
      chk("drain_head_r1", 64'(q_r1_rn), 64'(k + 1));
      chk("drain_q_valid", 64'(q_valid), 64'd1);
      tick();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("bubble_valid", 64'(q_valid), 64'd0);
    chk("bubble_unit", 64'(q_unit), 64'd0);
    chk("bubble_rd", 64'(q_rd_rn), 64'd0);
    chk("bubble_pc", 64'(q_pc), 64'd0);
    tick();
    chk("underflow_count", 64'(count), 64'd0);
    sc_ready = 1'b0;
    drive(1'b1, 6'd0, 64'h100);
    tick();
    sc_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k < 10) drive(1'b1, 6'(k), 64'h100 + 64'(8 * k));
      else drive(1'b0, 6'd0, 64'd0);
      #1;
      chk("stream_pc", q_pc, 64'h100 + 64'(8 * (k - 1)));
      chk("stream_count", 64'(count), 64'd1);
      tick();
    end
    chk("stream_end_count", 64'(count), 64'd0);
    sc_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 6'(k), 64'(k));
      tick();
    end
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 6'd9, 64'd9);
    sc_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0;
    sc_ready = 1'b0;
    drive(1'b0, 6'd0, 64'd0);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_q_valid", 64'(q_valid), 64'd0);
    drive(1'b1, 6'd10, 64'd10);
    tick();
    drive(1'b0, 6'd0, 64'd0);
    #1;
    chk("post_flush_head", 64'(q_rd_rn), 64'd10);
    chk("post_flush_count", 64'(count), 64'd1);
    drive(1'b1, 6'd11, 64'd11);
    tick();
    drive(1'b0, 6'd0, 64'd0);
    #1;
    chk("mid_count", 64'(count), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_q_valid", 64'(q_valid), 64'd0);
    chk("async_empty", 64'(empty), 64'd1);
    chk("async_in_ready", 64'(in_ready), 64'd1);
    chk("async_rd", 64'(q_rd_rn), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    drive(1'b1, 6'd7, 64'd7);
    sc_ready = 1'b1;
    #1;
`ifdef DECODE_QUEUE_BYPASS_EN
    chk("byp_q_valid", 64'(q_valid), 64'd1);
    chk("byp_rd", 64'(q_rd_rn), 64'd7);
    tick();
    drive(1'b0, 6'd0, 64'd0);
    #1;
    chk("byp_count", 64'(count), 64'd0);
    chk("byp_after_valid", 64'(q_valid), 64'd0);
`else
    chk("lat_q_valid", 64'(q_valid), 64'd0);
    chk("lat_rd", 64'(q_rd_rn), 64'd0);
    tick();
    drive(1'b0, 6'd0, 64'd0);
    #1;
    chk("lat_count", 64'(count), 64'd1);
    chk("lat_next_rd", 64'(q_rd_rn), 64'd7);
    chk("lat_next_valid", 64'(q_valid), 64'd1);
    tick();
    chk("lat_drain_empty", 64'(empty), 64'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
